// File: rtl/ob_pkg.sv
// Shared types and elaboration helpers for the table-count carry-propagate resolver.
package ob_pkg;

    // Resolver control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } cpa_state_t;

    localparam int unsigned CpaDefaultW     = 32;
    localparam int unsigned CpaDefaultChunk = 8;

    // Number of chunk cycles needed to resolve a W-bit word.
    function automatic int unsigned cpa_nchunk(input int unsigned w, input int unsigned chunk);
        return w / chunk;
    endfunction

endpackage

// File: rtl/ob_cpa_chunk.sv
// Narrow combinational adder resolving one CHUNK-bit slice of the carry-save pair.
module ob_cpa_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);

    // Widen by one bit so the slice carry-out falls out of the add.
    always_comb begin
        {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
    end

endmodule

// File: rtl/ob_table_cnt_cpa.sv
// Sequential carry-propagate resolver: adds a carry-save pair CHUNK bits per cycle.
// Optional build macro OB_TABLE_CNT_CPA_SAT_EN saturates out_sum_o to all-ones on carry out.
module ob_table_cnt_cpa
    import ob_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_s_i,
    input  logic [W-1:0] in_c_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_sum_o,
    output logic         out_ovf_o
);

    localparam int unsigned NChunk = cpa_nchunk(W, CHUNK);
    localparam int unsigned KW     = (NChunk > 1) ? $clog2(NChunk) : 1;

    if ((W % CHUNK) != 0) begin : g_chunk_check
        $error("ob_table_cnt_cpa: W must be a multiple of CHUNK");
    end

    cpa_state_t      state_q;
    logic [W-1:0]    s_q;
    logic [W-1:0]    c_q;
    logic [W-1:0]    sum_q;
    logic [KW-1:0]   k_q;
    logic            cy_q;
    logic            ovf_q;
    logic            vld_q;

    logic [CHUNK-1:0] add_a;
    logic [CHUNK-1:0] add_b;
    logic [CHUNK-1:0] add_s;
    logic             add_co;
    logic             last_chunk;
    int unsigned      base;

    // Select the operand slice addressed by the chunk index.
    always_comb begin
        base       = 32'(k_q) * CHUNK;
        add_a      = s_q[base +: CHUNK];
        add_b      = c_q[base +: CHUNK];
        last_chunk = (k_q == KW'(NChunk - 1));
    end

    ob_cpa_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i  (add_a),
        .b_i  (add_b),
        .ci_i (cy_q),
        .s_o  (add_s),
        .co_o (add_co)
    );

    // Upstream may hand over a new pair while the finished result is being taken.
    always_comb begin
        in_rdy_o = (state_q == StIdle) | ((state_q == StDone) & out_rdy_i);
    end

    // Control FSM with operand, sum, index and carry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            cy_q    <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_vld_i) begin
                        s_q     <= in_s_i;
                        c_q     <= in_c_i;
                        k_q     <= '0;
                        cy_q    <= 1'b0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    sum_q[base +: CHUNK] <= add_s;
                    cy_q                 <= add_co;
                    k_q                  <= k_q + KW'(1);
                    if (last_chunk) begin
                        ovf_q   <= add_co;
                        vld_q   <= 1'b1;
                        state_q <= StDone;
`ifdef OB_TABLE_CNT_CPA_SAT_EN
                        // Later assignment overrides the slice write above.
                        if (add_co) begin
                            sum_q <= '1;
                        end
`endif
                    end
                end
                StDone: begin
                    if (out_rdy_i) begin
                        vld_q <= 1'b0;
                        if (in_vld_i) begin
                            s_q     <= in_s_i;
                            c_q     <= in_c_i;
                            k_q     <= '0;
                            cy_q    <= 1'b0;
                            state_q <= StBusy;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_vld_o = vld_q;
    assign out_sum_o = sum_q;
    assign out_ovf_o = ovf_q;

endmodule

// File: tb/tb_ob_table_cnt_cpa.sv
// Self-checking bench for ob_table_cnt_cpa: directed cases plus randomized CSA-tree pairs.
module tb_ob_table_cnt_cpa;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_s;
    logic [31:0] in_c;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_sum;
    logic        out_ovf;

    int total;
    int bad;

    ob_table_cnt_cpa #(
        .W     (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (in_vld),
        .in_rdy_o  (in_rdy),
        .in_s_i    (in_s),
        .in_c_i    (in_c),
        .out_vld_o (out_vld),
        .out_rdy_i (out_rdy),
        .out_sum_o (out_sum),
        .out_ovf_o (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 33-bit addition, saturated when the build asks for it.
    function automatic logic [32:0] ref_add(input logic [31:0] s, input logic [31:0] c);
        logic [32:0] t;
        t = {1'b0, s} + {1'b0, c};
`ifdef OB_TABLE_CNT_CPA_SAT_EN
        if (t[32]) t[31:0] = 32'hFFFF_FFFF;
`endif
        return t;
    endfunction

    // Present a pair (in_rdy assumed high), then count edges until out_vld rises.
    task automatic run_op(input logic [31:0] s, input logic [31:0] c, output int lat);
        in_s   = s;
        in_c   = c;
        in_vld = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        in_s   = $urandom;
        in_c   = $urandom;
        lat    = 0;
        while (out_vld !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || out_sum !== 32'h0 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b vld=%b sum=%h ovf=%b, need rdy=1 vld=0 sum=0 ovf=0",
                     in_rdy, out_vld, out_sum, out_ovf);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ts [3];
        logic [31:0] tc [3];
        logic [31:0] es [3];
        logic        eo [3];
        int          lat;
        ts[0] = 32'h0000_1234; tc[0] = 32'h0000_0010; es[0] = 32'h0000_1244; eo[0] = 1'b0;
        ts[1] = 32'h00FF_FFFF; tc[1] = 32'h0000_0002; es[1] = 32'h0100_0001; eo[1] = 1'b0;
        ts[2] = 32'hFFFF_FFFF; tc[2] = 32'h0000_0002; eo[2] = 1'b1;
`ifdef OB_TABLE_CNT_CPA_SAT_EN
        es[2] = 32'hFFFF_FFFF;
`else
        es[2] = 32'h0000_0001;
`endif
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(ts[i], tc[i], lat);
            total++;
            if (lat !== 4) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, need 4", i, lat);
            end
            total++;
            if (out_sum !== es[i] || out_ovf !== eo[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got sum=%h ovf=%b, need sum=%h ovf=%b",
                         i, out_sum, out_ovf, es[i], eo[i]);
            end
            @(posedge clk); #1;
            total++;
            if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
                bad++;
                $display("FAIL directed_one_pulse[%0d]: got vld=%b rdy=%b, need vld=0 rdy=1",
                         i, out_vld, in_rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e1;
        logic [32:0] e2;
        int          lat;
        e1 = ref_add(32'hDEAD_BEEF, 32'h0123_4560);
        e2 = ref_add(32'h0000_0F00, 32'h0000_0100);
        out_rdy = 1'b0;
        run_op(32'hDEAD_BEEF, 32'h0123_4560, lat);
        total++;
        if (lat !== 4 || out_sum !== e1[31:0] || out_ovf !== e1[32]) begin
            bad++;
            $display("FAIL bp_first: got lat=%0d sum=%h ovf=%b, need lat=4 sum=%h ovf=%b",
                     lat, out_sum, out_ovf, e1[31:0], e1[32]);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_vld !== 1'b1 || in_rdy !== 1'b0 || out_sum !== e1[31:0]) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h, need vld=1 rdy=0 sum=%h",
                         i, out_vld, in_rdy, out_sum, e1[31:0]);
            end
        end
        in_s    = 32'h0000_0F00;
        in_c    = 32'h0000_0100;
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        #1;
        total++;
        if (in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got in_rdy=%b, need 1", in_rdy);
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        in_s   = $urandom;
        in_c   = $urandom;
        lat    = 0;
        while (out_vld !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 4 || out_sum !== e2[31:0] || out_ovf !== e2[32]) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d sum=%h ovf=%b, need lat=4 sum=%h ovf=%b",
                     lat, out_sum, out_ovf, e2[31:0], e2[32]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        int vld_seen;
        int lat;
        out_rdy = 1'b1;
        in_s    = 32'hFFFF_FFFF;
        in_c    = 32'h0000_0005;
        in_vld  = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || out_sum !== 32'h0 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL midreset_values: got rdy=%b vld=%b sum=%h ovf=%b, need 1 0 0 0",
                     in_rdy, out_vld, out_sum, out_ovf);
        end
        #2 rst_n = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_vld === 1'b1) vld_seen++;
        end
        total++;
        if (vld_seen !== 0) begin
            bad++;
            $display("FAIL midreset_no_vld: got %0d valid cycles, need 0", vld_seen);
        end
        run_op(32'h0000_1234, 32'h0000_0010, lat);
        total++;
        if (lat !== 4 || out_sum !== 32'h0000_1244 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL midreset_next_op: got lat=%0d sum=%h ovf=%b, need lat=4 sum=00001244 ovf=0",
                     lat, out_sum, out_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] exp_sum [$];
        logic        exp_ovf [$];
        logic [31:0] words [$];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [31:0] tot;
        logic [32:0] raw;
        logic        fire_in;
        logic [31:0] es;
        logic        eo;
        int          sent;
        int          done;
        int          cyc;
        sent = 0;
        done = 0;
        cyc  = 0;
        while (done < 1000 && cyc < 40000) begin
            if (in_vld === 1'b0 && sent < 1000 && $urandom_range(0, 3) != 0) begin
                words.delete();
                tot = 32'h0;
                for (int i = 0; i < 8; i++) begin
                    a = $urandom;
                    words.push_back(a);
                    tot = tot + a;
                end
                while (words.size() > 2) begin
                    a = words.pop_front();
                    b = words.pop_front();
                    d = words.pop_front();
                    words.push_back(a ^ b ^ d);
                    words.push_back(((a & b) | (a & d) | (b & d)) << 1);
                end
                in_s   = words[0];
                in_c   = words[1];
                in_vld = 1'b1;
            end
            out_rdy = 1'($urandom_range(0, 1));
            #1;
            if (out_vld === 1'b1 && out_rdy === 1'b1) begin
                total++;
                if (exp_sum.size() == 0) begin
                    bad++;
                    $display("FAIL rand_unexpected: got sum=%h with no pair outstanding", out_sum);
                end else begin
                    es = exp_sum.pop_front();
                    eo = exp_ovf.pop_front();
                    if (out_sum !== es || out_ovf !== eo) begin
                        bad++;
                        $display("FAIL rand_op[%0d]: got sum=%h ovf=%b, need sum=%h ovf=%b",
                                 done, out_sum, out_ovf, es, eo);
                    end
                end
                done++;
            end
            fire_in = in_vld & in_rdy;
            if (fire_in) begin
                // Final carry comes from the pair itself; the wrapped sum is the tree total.
                raw = {1'b0, in_s} + {1'b0, in_c};
                es  = tot;
`ifdef OB_TABLE_CNT_CPA_SAT_EN
                if (raw[32]) es = 32'hFFFF_FFFF;
`endif
                exp_sum.push_back(es);
                exp_ovf.push_back(raw[32]);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (fire_in) in_vld = 1'b0;
        end
        total++;
        if (done != 1000) begin
            bad++;
            $display("FAIL rand_complete: got %0d results, need 1000", done);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        in_s    = 32'h0;
        in_c    = 32'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
